// File: rtl/scan_display_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Holds the scan phase, digit count and the hex-to-segment table.
package scan_display_pkg;

    typedef enum logic {
        PH_ON    = 1'b0,
        PH_BLANK = 1'b1
    } phase_t;

    localparam int NUM_DIGITS = 4;

    // Segment patterns {g,f,e,d,c,b,a} for hex digits 0..F.
    localparam logic [6:0] SEG7_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/scan_display_hex_to_seg7.sv
// Combinational nibble to seven-segment lookup.
// Output bit0 is segment a, bit6 is segment g, active-high.
module hex_to_seg7
    import scan_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG7_TABLE[nibble];

endmodule

// File: rtl/scan_display.sv
// Time-multiplexed 4-digit seven-segment driver with a double-buffered
// frame; new frames are swapped in only at the end of a full scan.
module scan_display
    import scan_display_pkg::*;
#(
    parameter int ON_CYCLES    = 48,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  mask_in,
    input  logic        load,
    output logic        ready,
    output logic [3:0]  digit,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int TMAX = max2(ON_CYCLES, BLANK_CYCLES);
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] ON_LAST    = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
    localparam logic [1:0]    IDX_LAST   = 2'(NUM_DIGITS - 1);

    phase_t        phase;
    logic [1:0]    idx;
    logic [TW-1:0] timer;

    logic [15:0] act_value;
    logic [3:0]  act_dp;
    logic [3:0]  act_mask;

    logic [15:0] sh_value;
    logic [3:0]  sh_dp;
    logic [3:0]  sh_mask;
    logic        shadow_full;

    logic        on_end;
    logic        blank_end;
    logic        boundary;
    logic [3:0]  nibble;
    logic [6:0]  lut_seg;

    assign on_end    = (phase == PH_ON) && (timer == ON_LAST);
    assign blank_end = (phase == PH_BLANK) && (timer == BLANK_LAST);
    assign boundary  = blank_end && (idx == IDX_LAST);

    assign nibble = act_value[idx*4 +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble),
        .seg    (lut_seg)
    );

    always_comb begin
        digit = 4'b0000;
        seg   = 7'h00;
        dp    = 1'b0;
        if (phase == PH_ON) begin
            digit = 4'b0001 << idx;
            seg   = act_mask[idx] ? 7'h00 : lut_seg;
            dp    = act_dp[idx] & ~act_mask[idx];
        end
    end

    assign ready      = ~shadow_full;
    assign frame_done = boundary;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= PH_ON;
            idx         <= 2'd0;
            timer       <= '0;
            act_value   <= '0;
            act_dp      <= '0;
            act_mask    <= '0;
            sh_value    <= '0;
            sh_dp       <= '0;
            sh_mask     <= '0;
            shadow_full <= 1'b0;
        end else begin
            unique case (phase)
                PH_ON: begin
                    if (on_end) begin
                        timer <= '0;
                        phase <= PH_BLANK;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                PH_BLANK: begin
                    if (blank_end) begin
                        timer <= '0;
                        phase <= PH_ON;
                        idx   <= idx + 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    timer <= '0;
                    phase <= PH_ON;
                end
            endcase

            // Transfer needs a full shadow, capture needs an empty one,
            // so the two can never fight over shadow_full.
            if (boundary && shadow_full) begin
                act_value   <= sh_value;
                act_dp      <= sh_dp;
                act_mask    <= sh_mask;
                shadow_full <= 1'b0;
            end

            if (load && !shadow_full) begin
                sh_value    <= value;
                sh_dp       <= dp_in;
                sh_mask     <= mask_in;
                shadow_full <= 1'b1;
            end
        end
    end

endmodule
